gpio_input_port: RTL and testbench
==================================

# gpio_input_port

Memory-mapped input peripheral for the simpleRisc SoC that carries board buttons and switches toward the CPU. This is the inbound counterpart of the LED output path. Each input is synchronized and debounced, and rising edges are captured in sticky pending bits. The CPU reads state and clears events through a single-word request/acknowledge bus slave.

## Interface
- N_IN, 4, number of input pins (1..16)
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before the debounced level changes (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- pins  in  N_IN  raw asynchronous button/switch inputs
- bus_sel  in  1  request valid; held high until bus_ack
- bus_we  in  1  1 = write, 0 = read; valid while bus_sel
- bus_addr  in  4  byte offset; only word-aligned 0x0/0x4/0x8/0xC are legal
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data; valid only in the bus_ack cycle
- bus_ack  out  1  single-cycle completion pulse
- bus_err  out  1  high with bus_ack on an illegal access
- irq  out  1  level interrupt (present only with GPIO_IN_IRQ_EN)

## Operation
- Input path per pin: 2-flop synchronizer, then a debounce counter.
  - Counter resets when the synced input equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES−1, the debounced level flips and the counter clears.
- Edge detect: a rising edge of the debounced level sets PEND[i]. Falling edges are ignored.
- Event counter: a 16-bit CNT increments once per cycle in which any PEND bit is newly set (per cycle, not per pin). It wraps 0xFFFF→0x0000.
- Registers, all zero-extended to 32 bits:
  - 0x0 LEVEL: RO, debounced levels [N_IN−1:0]. Writes are ignored without error.
  - 0x4 PEND: W1C. Writing 1 clears the bit; writing 0 leaves it unchanged. A new set and a clear of the same bit in the same cycle resolve to set.
  - 0x8 CNT: read returns CNT. Any write clears CNT to 0; an increment in the same cycle is lost.
  - 0xC MASK: RW [N_IN−1:0] (see Configuration).
- bus_err: asserted when bus_addr[1:0] ≠ 0. The access is then ignored, and bus_rdata is 0.
- Reset (reset=0 at a clock edge) clears synchronizers, counters, levels, PEND, CNT, MASK, bus_ack, bus_err, bus_rdata and irq. This also applies mid-debounce or mid-transaction: a pending request is dropped without ack.

## Timing
- All outputs are 0 out of reset.
- Bus handshake:
  - bus_ack pulses in the cycle after bus_sel is sampled high with bus_ack low.
  - The write takes effect at the same edge that raises bus_ack.
  - The master must drop bus_sel in the ack cycle. If bus_sel is still high the cycle after ack, it is a new request (ack no more often than every other cycle).
- Read data reflects register state sampled at the edge that raises bus_ack.
- Pin-to-LEVEL latency is 2 (sync) + DEBOUNCE_CYCLES cycles from the first stable sampled value.
- PEND sets 1 cycle after the LEVEL rise. irq follows PEND/MASK with 1 cycle of registered delay.

## Configuration
- GPIO_IN_IRQ_EN defined:
  - MASK register is implemented.
  - irq = registered OR of (PEND & MASK).
- Undefined:
  - No irq port.
  - MASK reads as 0, and writes to 0xC complete with ack and no error.

## Structure
- Package gpio_in_pkg holds:
  - register offset constants: GPIO_LEVEL_OFF, GPIO_PEND_OFF, GPIO_CNT_OFF, GPIO_MASK_OFF
  - CNT width constant (16)
  - the counter-width function clog2(DEBOUNCE_CYCLES)
- One sub-module, gpio_debounce: synchronizer plus debounce counter for one pin. It outputs the level and a one-cycle rise pulse, and is instantiated N_IN times via generate.

## Test plan
Run with DEBOUNCE_CYCLES=4, N_IN=4.
- Reset: hold reset=0 for 3 cycles with pins=4'hF → all outputs 0. After release, LEVEL reads 0 until 6 stable cycles have elapsed.
- Bounce: toggle pins[0] 1/0 every cycle for 10 cycles, then hold 1 → LEVEL=0x1 exactly 6 cycles after the hold starts, PEND=0x1, CNT=1.
- W1C race: with PEND=0x3, write 0x1 to 0x4 in the same cycle that pin 0 rises again → PEND stays 0x3. A later write of 0x3 → PEND=0x0.
- Counter wrap and clear: force 65536 events → CNT reads 0x0000. Write 0x8 → CNT=0.
- Bus errors and handshake: read at addr 0x2 → ack with bus_err=1, rdata=0. bus_sel held for 3 cycles → acks on cycles 2 and 4 only.
- Interrupt (with GPIO_IN_IRQ_EN): MASK=0x4, rise on pin 2 → irq=1 one cycle after PEND[2] is set. W1C of 0x4 → irq=0 on the next cycle. Without the macro, a read of 0xC returns 0.

Source files
------------

// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - shared constants and helpers for the GPIO input port
package gpio_in_pkg;

   // Byte offsets of the four software-visible registers
   localparam logic [3:0] GPIO_LEVEL_OFF = 4'h0;
   localparam logic [3:0] GPIO_PEND_OFF  = 4'h4;
   localparam logic [3:0] GPIO_CNT_OFF   = 4'h8;
   localparam logic [3:0] GPIO_MASK_OFF  = 4'hC;

   // Width of the software event counter
   localparam int GPIO_CNT_W = 16;

   // Bits needed to hold 0..value-1; never less than one bit
   function automatic int clog2(input int unsigned value);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if (((value - 1) >> i) != 0) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - two-flop synchronizer and debounce counter for one pin
module gpio_debounce
   import gpio_in_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise
);

   localparam int CW = clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronize the raw pin, then require a full run of disagreeing
   // samples before the debounced level follows it
   always_comb begin
      sync1_d = pin;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync2_q;
         cnt_d   = '0;
         rise_d  = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; rise is registered so it lands the cycle after the level flips
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/gpio_input_port.sv
// rtl/gpio_input_port.sv - debounced GPIO input bus slave; GPIO_IN_IRQ_EN adds MASK and irq
module gpio_input_port
   import gpio_in_pkg::*;
#(
   parameter int N_IN            = 4,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_IN-1:0] pins,
   input  logic            bus_sel,
   input  logic            bus_we,
   input  logic [3:0]      bus_addr,
   input  logic [31:0]     bus_wdata,
   output logic [31:0]     bus_rdata,
   output logic            bus_ack,
   output logic            bus_err
`ifdef GPIO_IN_IRQ_EN
   ,
   output logic            irq
`endif
);

   logic [N_IN-1:0]       level_vec;
   logic [N_IN-1:0]       rise_vec;

   logic [N_IN-1:0]       pend_q, pend_d;
   logic [GPIO_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [N_IN-1:0]       mask_rd;

   logic                  req;
   logic                  legal;
   logic                  wr_en;
   logic                  rd_en;
   logic [3:0]            reg_off;
   logic [31:0]           rd_word;

   logic                  unused_wdata;
   assign unused_wdata = ^bus_wdata[31:N_IN];

   genvar i;
   generate
      for (i = 0; i < N_IN; i++) begin : g_pin
         gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .pin  (pins[i]),
            .level(level_vec[i]),
            .rise (rise_vec[i])
         );
      end
   endgenerate

   // Accept a request only when no ack is outstanding, so a held select
   // produces at most one ack every other cycle
   always_comb begin
      req     = bus_sel & ~ack_q;
      legal   = (bus_addr[1:0] == 2'b00);
      reg_off = {bus_addr[3:2], 2'b00};
      wr_en   = req & legal & bus_we;
      rd_en   = req & legal & ~bus_we;
   end

   // Pending bits and event counter; a new rise beats a same-cycle clear,
   // while a counter write beats a same-cycle increment
   always_comb begin
      pend_d = pend_q;
      if (wr_en && (reg_off == GPIO_PEND_OFF)) begin
         pend_d = pend_q & ~bus_wdata[N_IN-1:0];
      end
      pend_d = pend_d | rise_vec;

      evt_cnt_d = evt_cnt_q;
      if (wr_en && (reg_off == GPIO_CNT_OFF)) begin
         evt_cnt_d = '0;
      end else if (|rise_vec) begin
         evt_cnt_d = evt_cnt_q + 1'b1;
      end
   end

`ifdef GPIO_IN_IRQ_EN
   logic [N_IN-1:0] mask_q, mask_d;
   logic            irq_q, irq_d;

   // Interrupt mask register and registered level interrupt
   always_comb begin
      mask_d = mask_q;
      if (wr_en && (reg_off == GPIO_MASK_OFF)) begin
         mask_d = bus_wdata[N_IN-1:0];
      end
      irq_d   = |(pend_q & mask_q);
      mask_rd = mask_q;
   end

   // Mask and interrupt registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign mask_rd = '0;
`endif

   // Read mux over current register state, zero-extended to a word
   always_comb begin
      rd_word = '0;
      case (reg_off)
         GPIO_LEVEL_OFF: rd_word = {{(32-N_IN){1'b0}}, level_vec};
         GPIO_PEND_OFF:  rd_word = {{(32-N_IN){1'b0}}, pend_q};
         GPIO_CNT_OFF:   rd_word = {{(32-GPIO_CNT_W){1'b0}}, evt_cnt_q};
         GPIO_MASK_OFF:  rd_word = {{(32-N_IN){1'b0}}, mask_rd};
         default:        rd_word = '0;
      endcase
   end

   // Response: one-cycle ack, error on misaligned offsets, data only on legal reads
   always_comb begin
      ack_d   = req;
      err_d   = req & ~legal;
      rdata_d = rd_en ? rd_word : '0;
   end

   // Register file and bus response flops
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_q    <= '0;
         evt_cnt_q <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         pend_q    <= pend_d;
         evt_cnt_q <= evt_cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus_ack   = ack_q;
   assign bus_err   = err_q;
   assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// tb/tb_gpio_input_port.sv - directed self-checking bench for gpio_input_port (GPIO_IN_IRQ_EN aware)
module tb_gpio_input_port;
   import gpio_in_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  pins, pins_w;
   logic        bus_sel, w_sel, bus_we;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata, w_rdata;
   logic        bus_ack, w_ack, bus_err, w_err;
`ifdef GPIO_IN_IRQ_EN
   logic        irq, w_irq;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Main instance as in the test plan
   gpio_input_port #(.N_IN(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .pins(pins),
      .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
`ifdef GPIO_IN_IRQ_EN
      , .irq(irq)
`endif
   );

   // Fast-debounce instance so one event per cycle can drive the counter through a wrap
   gpio_input_port #(.N_IN(4), .DEBOUNCE_CYCLES(2)) dut_w (
      .clk(clk), .reset(reset), .pins(pins_w),
      .bus_sel(w_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(w_rdata), .bus_ack(w_ack), .bus_err(w_err)
`ifdef GPIO_IN_IRQ_EN
      , .irq(w_irq)
`endif
   );

   task automatic bus_xfer(input bit wide, input logic we, input logic [3:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
      int   lat;
      logic ack;
      bus_we    = we;
      bus_addr  = addr;
      bus_wdata = wdata;
      if (wide) w_sel = 1'b1;
      else      bus_sel = 1'b1;
      lat = 0;
      ack = 1'b0;
      while (!ack && lat < 8) begin
         @(negedge clk);
         lat++;
         ack = wide ? w_ack : bus_ack;
      end
      rdata   = wide ? w_rdata : bus_rdata;
      err     = wide ? w_err : bus_err;
      bus_sel = 1'b0;
      w_sel   = 1'b0;
      bus_we  = 1'b0;
      if (!ack) begin
         vectors++;
         miscompares++;
         $display("FAIL bus_timeout addr=%h got no ack want ack within 8 cycles", addr);
      end
   endtask

   task automatic do_reset(input logic [3:0] p);
      reset = 1'b0;
      pins  = p;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        er;
      reset    = 1'b0;
      pins     = 4'hF;
      bus_sel  = 1'b1;
      bus_we   = 1'b0;
      bus_addr = GPIO_LEVEL_OFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ack cycle=%0d got=%b want=0", i, bus_ack);
         end
      end
      vectors++;
      if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", bus_err); end
      vectors++;
      if (bus_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", bus_rdata); end
`ifdef GPIO_IN_IRQ_EN
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b want=0", irq); end
`endif
      bus_sel = 1'b0;
      reset   = 1'b1;
      repeat (5) @(negedge clk);
      bus_xfer(0, 1'b0, GPIO_LEVEL_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_level_at5 got=%h want=0", rd); end
      do_reset(4'hF);
      repeat (6) @(negedge clk);
      bus_xfer(0, 1'b0, GPIO_LEVEL_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'hF) begin miscompares++; $display("FAIL reset_level_at6 got=%h want=f", rd); end
   endtask

   // Reset, bounce pin 0 for 10 cycles, hold it high, read addr with ack k cycles into the hold
   task automatic bounce_then_read(input int k, input logic [3:0] addr, output logic [31:0] rd);
      logic er;
      do_reset(4'h0);
      for (int i = 0; i < 10; i++) begin
         pins = (i % 2 == 0) ? 4'h1 : 4'h0;
         @(negedge clk);
      end
      pins = 4'h1;
      repeat (k) @(negedge clk);
      bus_xfer(0, 1'b0, addr, 32'h0, rd, er);
   endtask

   task automatic test_bounce();
      logic [31:0] rd;
      logic        er;
      bounce_then_read(5, GPIO_LEVEL_OFF, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL bounce_level_at5 got=%h want=0", rd); end
      bounce_then_read(6, GPIO_LEVEL_OFF, rd);
      vectors++;
      if (rd !== 32'h1) begin miscompares++; $display("FAIL bounce_level_at6 got=%h want=1", rd); end
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h1) begin miscompares++; $display("FAIL bounce_pend got=%h want=1", rd); end
      bus_xfer(0, 1'b0, GPIO_CNT_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h1) begin miscompares++; $display("FAIL bounce_cnt got=%h want=1", rd); end
      bounce_then_read(6, GPIO_PEND_OFF, rd);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL bounce_pend_at6 got=%h want=0", rd); end
      bounce_then_read(7, GPIO_PEND_OFF, rd);
      vectors++;
      if (rd !== 32'h1) begin miscompares++; $display("FAIL bounce_pend_at7 got=%h want=1", rd); end
   endtask

   task automatic test_w1c_race();
      logic [31:0] rd;
      logic        er;
      do_reset(4'h0);
      pins = 4'h3;
      repeat (10) @(negedge clk);
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h3) begin miscompares++; $display("FAIL race_setup_pend got=%h want=3", rd); end
      pins = 4'h2;
      repeat (10) @(negedge clk);
      pins = 4'h3;
      repeat (6) @(negedge clk);
      bus_xfer(0, 1'b1, GPIO_PEND_OFF, 32'h1, rd, er);
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h3) begin miscompares++; $display("FAIL race_pend got=%h want=3", rd); end
      bus_xfer(0, 1'b0, GPIO_CNT_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h2) begin miscompares++; $display("FAIL race_cnt got=%h want=2", rd); end
      bus_xfer(0, 1'b1, GPIO_PEND_OFF, 32'h2, rd, er);
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h1) begin miscompares++; $display("FAIL w1c_bit1 got=%h want=1", rd); end
      bus_xfer(0, 1'b1, GPIO_PEND_OFF, 32'h3, rd, er);
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL w1c_all got=%h want=0", rd); end
   endtask

   task automatic test_cnt_clear();
      logic [31:0] rd;
      logic        er;
      pins = 4'h7;
      repeat (6) @(negedge clk);
      bus_xfer(0, 1'b1, GPIO_CNT_OFF, 32'hFFFF_FFFF, rd, er);
      bus_xfer(0, 1'b0, GPIO_CNT_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL cnt_clear_race got=%h want=0", rd); end
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h4) begin miscompares++; $display("FAIL cnt_clear_pend got=%h want=4", rd); end
   endtask

   task automatic test_bus_err();
      logic [31:0] rd;
      logic        er;
      bus_xfer(0, 1'b0, 4'h2, 32'h0, rd, er);
      vectors++;
      if (er !== 1'b1) begin miscompares++; $display("FAIL err_rd_flag got=%b want=1", er); end
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL err_rd_data got=%h want=0", rd); end
      bus_xfer(0, 1'b1, 4'h6, 32'hF, rd, er);
      vectors++;
      if (er !== 1'b1) begin miscompares++; $display("FAIL err_wr_flag got=%b want=1", er); end
      bus_xfer(0, 1'b0, GPIO_PEND_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h4 || er !== 1'b0) begin
         miscompares++;
         $display("FAIL err_wr_ignored pend got=%h err=%b want=4 err=0", rd, er);
      end
      bus_xfer(0, 1'b1, GPIO_LEVEL_OFF, 32'hF, rd, er);
      vectors++;
      if (er !== 1'b0) begin miscompares++; $display("FAIL level_wr_err got=%b want=0", er); end
      bus_xfer(0, 1'b0, GPIO_LEVEL_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h7) begin miscompares++; $display("FAIL level_ro got=%h want=7", rd); end
   endtask

   task automatic test_handshake();
      logic [3:0] seen;
      @(negedge clk);
      bus_we   = 1'b0;
      bus_addr = GPIO_LEVEL_OFF;
      bus_sel  = 1'b1;
      @(negedge clk); seen[0] = bus_ack;
      @(negedge clk); seen[1] = bus_ack;
      @(negedge clk); seen[2] = bus_ack;
      bus_sel = 1'b0;
      @(negedge clk); seen[3] = bus_ack;
      vectors++;
      if (seen !== 4'b0101) begin miscompares++; $display("FAIL held_sel_acks got=%b want=0101", seen); end
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      logic        er;
`ifdef GPIO_IN_IRQ_EN
      bus_xfer(0, 1'b1, GPIO_PEND_OFF, 32'hF, rd, er);
      pins = 4'h3;
      repeat (10) @(negedge clk);
      bus_xfer(0, 1'b1, GPIO_MASK_OFF, 32'h4, rd, er);
      bus_xfer(0, 1'b0, GPIO_MASK_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h4) begin miscompares++; $display("FAIL mask_rb got=%h want=4", rd); end
      pins = 4'h7;
      repeat (7) @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got=%b want=0", irq); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set got=%b want=1", irq); end
      bus_xfer(0, 1'b1, GPIO_PEND_OFF, 32'h4, rd, er);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold got=%b want=1", irq); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got=%b want=0", irq); end
`else
      bus_xfer(0, 1'b1, GPIO_MASK_OFF, 32'hF, rd, er);
      vectors++;
      if (er !== 1'b0) begin miscompares++; $display("FAIL mask_wr_err got=%b want=0", er); end
      bus_xfer(0, 1'b0, GPIO_MASK_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL mask_absent got=%h want=0", rd); end
`endif
   endtask

   task automatic test_cnt_wrap();
      logic [31:0] rd;
      logic        er;
      logic [3:0]  cur, prev;
      int          t, ev, target;
      t    = 0;
      ev   = 0;
      prev = 4'h0;
      cur  = 4'h0;
      for (int phase = 0; phase < 2; phase++) begin
         target = (phase == 0) ? 65536 : 65539;
         while (ev < target && t < 80000) begin
            for (int i = 0; i < 4; i++) begin
               cur[i] = (t >= i) && (((t - i) % 4) >= 2);
            end
            if ((cur & ~prev) != 4'h0) ev++;
            pins_w = cur;
            prev   = cur;
            @(negedge clk);
            t++;
         end
         repeat (12) @(negedge clk);
         bus_xfer(1, 1'b0, GPIO_CNT_OFF, 32'h0, rd, er);
         vectors++;
         if (phase == 0 && rd !== 32'h0) begin
            miscompares++;
            $display("FAIL cnt_wrap got=%h want=0", rd);
         end else if (phase == 1 && rd !== 32'h3) begin
            miscompares++;
            $display("FAIL cnt_after_wrap got=%h want=3", rd);
         end
      end
      bus_xfer(1, 1'b1, GPIO_CNT_OFF, 32'h0, rd, er);
      bus_xfer(1, 1'b0, GPIO_CNT_OFF, 32'h0, rd, er);
      vectors++;
      if (rd !== 32'h0) begin miscompares++; $display("FAIL cnt_write_clear got=%h want=0", rd); end
   endtask

   initial begin
      reset     = 1'b0;
      pins      = 4'h0;
      pins_w    = 4'h0;
      bus_sel   = 1'b0;
      w_sel     = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = 4'h0;
      bus_wdata = 32'h0;
      test_reset();
      test_bounce();
      test_w1c_race();
      test_cnt_clear();
      test_bus_err();
      test_handshake();
      test_irq();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
